// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, block/round constants and the
// byte-level helpers (S-box lookup, GF(2^8) doubling, MixColumns column).
package aes_pkg;

   localparam int AES_NR       = 10;
   localparam int AES_BLOCK_W  = 128;
   localparam int AES_RK_IDX_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } aes_state_e;

   // Forward S-box, entry 0x00 in the top byte
   localparam logic [2047:0] AES_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return AES_SBOX[{~x, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      {a0, a1, a2, a3} = col;
      b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      return {b0, b1, b2, b3};
   endfunction

endpackage

// File: rtl/aes_final_round.sv
// Last AES round without AddRoundKey: SubBytes then ShiftRows, no MixColumns.
module aes_final_round
   import aes_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] data,
   output logic [AES_BLOCK_W-1:0] result
);

   logic [AES_BLOCK_W-1:0] sub_out;

   subBytes u_sub (
      .data   (data),
      .result (sub_out)
   );

   shift_rows u_shift (
      .data   (sub_out),
      .result (result)
   );

endmodule

// File: rtl/encrypt_round.sv
// One full AES middle round without AddRoundKey: SubBytes, ShiftRows, MixColumns.
module encrypt_round
   import aes_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] data,
   output logic [AES_BLOCK_W-1:0] result
);

   logic [AES_BLOCK_W-1:0] sub_out;
   logic [AES_BLOCK_W-1:0] shift_out;

   subBytes u_sub (
      .data   (data),
      .result (sub_out)
   );

   shift_rows u_shift (
      .data   (sub_out),
      .result (shift_out)
   );

   genvar c;
   generate
      for (c = 0; c < 4; c++) begin : g_mix
         assign result[AES_BLOCK_W-1-32*c -: 32] = mix_column(shift_out[AES_BLOCK_W-1-32*c -: 32]);
      end
   endgenerate

endmodule

// File: rtl/shift_rows.sv
// Cyclic left rotation of row r by r bytes; state bytes are column-major.
module shift_rows
   import aes_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] data,
   output logic [AES_BLOCK_W-1:0] result
);

   genvar r, c;
   generate
      for (r = 0; r < 4; r++) begin : g_row
         for (c = 0; c < 4; c++) begin : g_col
            assign result[AES_BLOCK_W-1-8*(r+4*c) -: 8] =
               data[AES_BLOCK_W-1-8*(r+4*((c+r)%4)) -: 8];
         end
      end
   endgenerate

endmodule

// File: rtl/subBytes.sv
// Byte-wise S-box substitution over a full 128-bit AES state.
module subBytes
   import aes_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] data,
   output logic [AES_BLOCK_W-1:0] result
);

   genvar i;
   generate
      for (i = 0; i < 16; i++) begin : g_byte
         assign result[AES_BLOCK_W-1-8*i -: 8] = sbox(data[AES_BLOCK_W-1-8*i -: 8]);
      end
   endgenerate

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock over state_q,
// round keys fetched combinationally from the key-schedule RAM via rk_idx.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [AES_BLOCK_W-1:0]  in_block,
   output logic [AES_RK_IDX_W-1:0] rk_idx,
   input  logic [AES_BLOCK_W-1:0]  rk_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [AES_BLOCK_W-1:0]  out_block,
   output logic                    busy
);

   localparam logic [AES_RK_IDX_W-1:0] LAST_MID = AES_RK_IDX_W'(NR - 1);
   localparam logic [AES_RK_IDX_W-1:0] LAST_KEY = AES_RK_IDX_W'(NR);

   aes_state_e             state;
   logic [AES_RK_IDX_W-1:0] rnd;
   logic [AES_BLOCK_W-1:0] state_q;
   logic [AES_BLOCK_W-1:0] round_out;
   logic [AES_BLOCK_W-1:0] final_out;

   encrypt_round u_round (
      .data   (state_q),
      .result (round_out)
   );

   aes_final_round u_final (
      .data   (state_q),
      .result (final_out)
   );

   always_comb begin
      rk_idx = '0;
      case (state)
         ST_ROUND: rk_idx = rnd;
         ST_FINAL: rk_idx = LAST_KEY;
         default:  rk_idx = '0;
      endcase
   end

   assign out_block = state_q;

   // Handshake flags are registered alongside the state transition so they
   // always agree with the state the FSM has just entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rnd       <= '0;
         state_q   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  state_q  <= in_block ^ rk_data;
                  rnd      <= AES_RK_IDX_W'(1);
                  state    <= ST_ROUND;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ST_ROUND: begin
               state_q <= round_out ^ rk_data;
               if (rnd == LAST_MID) begin
                  rnd   <= LAST_KEY;
                  state <= ST_FINAL;
               end else begin
                  rnd <= rnd + AES_RK_IDX_W'(1);
               end
            end
            ST_FINAL: begin
               state_q   <= final_out ^ rk_data;
               state     <= ST_DONE;
               out_valid <= 1'b1;
            end
            ST_DONE: begin
               // No accept here: in_ready only rises once IDLE is entered
               if (out_ready) begin
                  state     <= ST_IDLE;
                  rnd       <= '0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               rnd       <= '0;
               state_q   <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a key-schedule RAM model and an
// ordered queue of expected ciphertexts.
module tb_aes_round_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_block;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_block;
   logic         busy;

   aes_round_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_block  (in_block),
      .rk_idx    (rk_idx),
      .rk_data   (rk_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_block (out_block),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int accepts = 0;
   int transfers = 0;
   logic [127:0] exp_q[$];
   int           acc_q[$];
   logic [7:0]   sb [256];
   logic [127:0] rk [11];
   logic         ov_prev = 1'b0;

   assign rk_data = (rk_idx <= 4'd10) ? rk[rk_idx] : 128'd0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box built from the GF(2^8) inverse and the affine map
   task automatic build_sbox();
      for (int v = 0; v < 256; v++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++)
            if (v != 0 && gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sb[v] = s;
      end
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
            rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   always @(posedge clk) cyc++;

   // Monitor: accepts, output latency at out_valid rise, ordered data check on transfer
   always @(negedge clk) begin
      if (rst) begin
         acc_q.delete();
         ov_prev = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            accepts++;
            acc_q.push_back(cyc);
         end
         if (out_valid && !ov_prev) begin
            if (acc_q.size() > 0) chk("latency", 128'(cyc - acc_q.pop_front()), 128'd11);
            else chk("valid_without_accept", 128'(out_valid), 128'd0);
         end
         if (out_valid && out_ready) begin
            transfers++;
            if (exp_q.size() > 0) chk("out_block", out_block, exp_q.pop_front());
            else chk("unexpected_out", 128'(out_valid), 128'd0);
         end
         ov_prev = out_valid;
      end
   end

   task automatic wait_accept(input bit drop);
      int n = accepts;
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (accepts > n) begin ok = 1'b1; break; end
      end
      chk("accept_timeout", 128'(ok), 128'd1);
      if (drop) in_valid = 1'b0;
   endtask

   task automatic wait_transfers(input int target);
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (transfers >= target) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      chk("output_timeout", 128'(ok), 128'd1);
   endtask

   task automatic wait_out_valid();
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin ok = 1'b1; break; end
      end
      chk("valid_timeout", 128'(ok), 128'd1);
   endtask

   task automatic start(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct);
      expand(key);
      exp_q.push_back(ct);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_block = pt;
   endtask

   initial begin
      int t0;
      int a0, a1;
      logic [127:0] hold;
      rst = 1'b1; in_valid = 1'b0; in_block = '0; out_ready = 1'b1;
      build_sbox();
      expand(KEY_C1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_rk_idx", 128'(rk_idx), 128'd0);
      chk("rst_out_block", out_block, 128'd0);

      // FIPS-197 C.1
      t0 = transfers;
      start(KEY_C1, PT_C1, CT_C1);
      wait_accept(1'b1);
      chk("busy_after_accept", 128'(busy), 128'd1);
      wait_transfers(t0 + 1);

      // FIPS-197 B with per-edge round-key index sequence
      t0 = transfers;
      expand(KEY_B);
      exp_q.push_back(CT_B);
      @(posedge clk); #1;
      in_valid = 1'b1; in_block = PT_B;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k == 0) chk("b_in_ready", 128'(in_ready), 128'd1);
         chk("rk_idx_seq", 128'(rk_idx), 128'(k));
         if (k == 0) begin @(posedge clk); #1; in_valid = 1'b0; end
      end
      wait_transfers(t0 + 1);

      // Backpressure: hold out_ready low for 20 cycles
      t0 = transfers;
      out_ready = 1'b0;
      start(KEY_C1, PT_C1, CT_C1);
      wait_accept(1'b1);
      wait_out_valid();
      hold = out_block;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_valid", 128'(out_valid), 128'd1);
         chk("bp_block", out_block, CT_C1);
         chk("bp_in_ready", 128'(in_ready), 128'd0);
      end
      chk("bp_stable", out_block, hold);
      chk("bp_no_transfer", 128'(transfers), 128'(t0));
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_valid_drop", 128'(out_valid), 128'd0);
      chk("bp_single_transfer", 128'(transfers), 128'(t0 + 1));

      // Back-to-back: in_valid held high across C.1 then B
      t0 = transfers;
      a0 = cyc;
      start(KEY_C1, PT_C1, CT_C1);
      wait_accept(1'b0);
      a0 = cyc;
      in_block = PT_B;
      exp_q.push_back(CT_B);
      wait_out_valid();
      expand(KEY_B);
      wait_accept(1'b1);
      a1 = cyc;
      chk("b2b_spacing", 128'(a1 - a0), 128'd12);
      wait_transfers(t0 + 2);
      repeat (3) @(posedge clk);
      #1 chk("b2b_no_double", 128'(transfers), 128'(t0 + 2));

      // Reset during round 5 aborts the block
      t0 = transfers;
      start(KEY_C1, PT_C1, CT_C1);
      void'(exp_q.pop_back());
      wait_accept(1'b1);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", 128'(out_valid), 128'd0);
      chk("abort_busy", 128'(busy), 128'd0);
      chk("abort_state_q", out_block, 128'd0);
      chk("abort_in_ready", 128'(in_ready), 128'd1);
      repeat (15) @(posedge clk);
      #1 chk("abort_no_output", 128'(transfers), 128'(t0));
      start(KEY_C1, PT_C1, CT_C1);
      wait_accept(1'b1);
      wait_transfers(t0 + 1);

      // All-zero key and block
      t0 = transfers;
      start(128'd0, 128'd0, CT_Z);
      wait_accept(1'b1);
      wait_transfers(t0 + 1);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 128'(exp_q.size()), 128'd0);
      chk("accept_count", 128'(accepts), 128'(transfers + 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption datapath controller that wraps the existing combinational `encrypt_round` stage. It accepts one 128-bit block and performs the initial AddRoundKey. It then iterates `encrypt_round` XOR round key for rounds 1–9, applies the final round (SubBytes + ShiftRows, no MixColumns) XOR key 10, and presents the ciphertext. In the CTR path it sits between the AXI4-Lite register/counter logic, which supplies counter blocks, and the keystream XOR, which consumes `out_block`. Round keys come from the key-schedule RAM through an index/data port.

## Interface
- `NR`, 10, number of rounds; only 10 (AES-128) is supported.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input block offered.
- `in_ready`  out  1  controller can accept a block.
- `in_block`  in  128  plaintext/counter block, byte 0 in bits [127:120].
- `rk_idx`  out  4  round-key index requested, 0..10.
- `rk_data`  in  128  round key for `rk_idx`; combinational (same-cycle) read.
- `out_valid`  out  1  ciphertext valid.
- `out_ready`  in  1  consumer accepts ciphertext.
- `out_block`  out  128  ciphertext.
- `busy`  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. A 4-bit round counter `rnd` and a 128-bit `state_q` are kept.
- **IDLE**
  - `in_ready=1`, `rk_idx=0`.
  - On `in_valid`, the controller loads `state_q <= in_block ^ rk_data`, sets `rnd <= 1` and moves to ROUND.
- **ROUND**
  - `rk_idx=rnd`.
  - Each cycle it loads `state_q <= encrypt_round(state_q) ^ rk_data` and increments `rnd`.
  - When `rnd==NR-1` (9) is processed, it moves to FINAL with `rnd=10`.
- **FINAL**
  - `rk_idx=10`.
  - It loads `state_q <= shift_rows(subBytes(state_q)) ^ rk_data` and moves to DONE.
- **DONE**
  - `out_valid=1` and `out_block=state_q`.
  - On `out_ready`, it moves to IDLE.
  - Until then it holds `out_block` stable and ignores `in_valid` (`in_ready=0`).
- `in_ready` is high only in IDLE. There is no accept in DONE, even when `out_ready` is high in the same cycle.
- `rk_idx` is a combinational decode of FSM state and `rnd`. It is valid in every state; reset value is 0.
- `out_block` equals `state_q` in all states. Consumers sample it only when `out_valid=1`.
- All XORs are full 128-bit with no width changes. `rnd` never exceeds 10. Illegal state encodings return to IDLE.

## Timing
- Reset values: state IDLE, `rnd=0`, `state_q=0`, `in_ready=1`, `out_valid=0`, `busy=0`, `rk_idx=0`, `out_block=0`.
- Accept edge is E0. Rounds 1–9 occur on E1–E9 and the final round on E10. `out_valid` rises in the cycle after E10, i.e. 11 cycles after the accept cycle.
- With `out_ready` held high, `out_valid` lasts exactly 1 cycle. IDLE follows, and the next accept can occur 1 cycle later. Minimum period is 12 cycles per block.
- Backpressure: `out_valid` and `out_block` stay constant while `out_ready=0`, for any number of cycles.
- `rst` during ROUND, FINAL or DONE aborts the block on the next edge. The controller returns to IDLE with reset values and emits no output for the aborted block.
- `in_valid` held through a busy period does not cause a double accept. The block is taken only in IDLE.
- The critical path is the round function plus XOR into `state_q`, one round per cycle.

## Structure
- Shared package `aes_pkg`:
  - FSM state enum (IDLE, ROUND, FINAL, DONE)
  - `AES_NR=10`
  - `AES_BLOCK_W=128`
  - `AES_RK_IDX_W=4`
- Sub-modules:
  - Reuse `encrypt_round` for rounds 1–9.
  - Add one small sub-module `aes_final_round`, which instantiates `subBytes` followed by `shift_rows` without MixColumns. It is shared by any later decrypt/final-stage work.
- AddRoundKey is an inline XOR; no separate module.

## Test plan
- **FIPS-197 C.1**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (bench key RAM model); block 00112233445566778899aabbccddeeff.
  - Required response: `out_block`=69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` 11 cycles after accept.
- **FIPS-197 B**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c; block 3243f6a8885a308d313198a2e0370734.
  - Required response: 3925841d02dc09fbdc118597196a0b32. `rk_idx` sequence per edge is 0,1,…,10.
- **Backpressure**
  - Stimulus: C.1 vector with `out_ready=0` for 20 cycles after `out_valid` rises.
  - Required response: `out_block` stable, `in_ready=0` throughout; a single transfer occurs when `out_ready` rises.
- **Back-to-back**
  - Stimulus: `in_valid` held high with C.1 then B blocks, `out_ready=1`.
  - Required response: both correct ciphertexts in order; accepts exactly 12 cycles apart; no double accept.
- **Reset mid-operation**
  - Stimulus: assert `rst` 1 cycle at round 5.
  - Required response: next cycle is IDLE, `out_valid=0`, `busy=0`, `state_q=0`. A following C.1 block encrypts correctly.
- **Zero vector**
  - Stimulus: all-zero key and block.
  - Required response: 66e94bd4ef8a2c3b884cfa59ca342b2e.
